// File: rtl/z80_block_compare_unit.sv
// Block-compare execute unit (CPI/CPD/CPIR/CPDR): one memory read per iteration,
// then a single-cycle z80fi retire packet carrying the BC/HL/F/IP results.
module z80_block_compare_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        ready,
    input  logic [15:0] insn,
    input  logic [7:0]  reg_a_in,
    input  logic [7:0]  reg_f_in,
    input  logic [15:0] reg_bc_in,
    input  logic [15:0] reg_hl_in,
    input  logic [15:0] reg_ip_in,
    output logic        mem_rd_req,
    output logic [15:0] mem_raddr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rd_ack,
    output logic        insn_err,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [7:0]  z80fi_mem_rdata,
    output logic [15:0] z80fi_reg_bc_out,
    output logic [15:0] z80fi_reg_hl_out,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [7:0]  z80fi_reg_f_out,
    output logic [1:0]  dbg_state
);

    // Handshakes: start is taken on a rising edge only while ready=1. mem_rd_req stays
    // high with mem_raddr stable until mem_rd_ack is sampled high; ack outside READ is ignored.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_RETIRE = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] insn_q;
    logic [7:0]  a_q;
    logic [7:0]  f_q;
    logic [15:0] bc_q;
    logic [15:0] hl_q;
    logic [15:0] ip_q;
    logic [7:0]  m_q;
    logic [15:0] cnt;

    logic        legal;
    logic        timeout;
    logic [7:0]  diff;
    logic [4:0]  half_sum;
    logic [15:0] bc_next;
    logic [15:0] hl_next;
    logic [15:0] ip_next;
    logic [7:0]  f_next;

    always_comb begin
        legal = (insn == 16'hA1ED) || (insn == 16'hA9ED) ||
                (insn == 16'hB1ED) || (insn == 16'hB9ED);
    end

    assign timeout = (ACK_TIMEOUT != 0) && (cnt == TO_LAST);

    // Second opcode byte: bit 3 selects decrement (A9/B9), bit 4 selects repeat (B1/B9).
    always_comb begin
        diff     = a_q - m_q;
        half_sum = {1'b0, a_q[3:0]} + {1'b0, ~m_q[3:0]} + 5'd1;
        bc_next  = bc_q - 16'd1;
        hl_next  = insn_q[11] ? (hl_q - 16'd1) : (hl_q + 16'd1);
        ip_next  = (insn_q[12] && (bc_next != 16'h0000) && (diff != 8'h00)) ? ip_q
                                                                            : ip_q + 16'd2;
        f_next   = {diff[7], diff == 8'h00, f_q[5], half_sum[4], f_q[3],
                    bc_q != 16'h0001, 1'b1, f_q[0]};
    end

    assign ready      = (state == ST_IDLE);
    assign mem_rd_req = (state == ST_READ);
    assign mem_raddr  = (state == ST_READ) ? hl_q : 16'h0000;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            insn_q           <= '0;
            a_q              <= '0;
            f_q              <= '0;
            bc_q             <= '0;
            hl_q             <= '0;
            ip_q             <= '0;
            m_q              <= '0;
            cnt              <= '0;
            insn_err         <= 1'b0;
            z80fi_valid      <= 1'b0;
            z80fi_insn       <= '0;
            z80fi_insn_len   <= '0;
            z80fi_mem_rdata  <= '0;
            z80fi_reg_bc_out <= '0;
            z80fi_reg_hl_out <= '0;
            z80fi_reg_ip_out <= '0;
            z80fi_reg_f_out  <= '0;
        end else begin
            insn_err    <= 1'b0;
            z80fi_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        insn_q <= insn;
                        a_q    <= reg_a_in;
                        f_q    <= reg_f_in;
                        bc_q   <= reg_bc_in;
                        hl_q   <= reg_hl_in;
                        ip_q   <= reg_ip_in;
                        cnt    <= '0;
                        if (legal) state    <= ST_READ;
                        else       insn_err <= 1'b1;
                    end
                end
                ST_READ: begin
                    // An ack arriving on the timeout cycle still completes the read.
                    if (mem_rd_ack) begin
                        m_q   <= mem_rdata;
                        state <= ST_RETIRE;
                    end else if (timeout) begin
                        insn_err <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RETIRE: begin
                    z80fi_valid      <= 1'b1;
                    z80fi_insn       <= {16'h0000, insn_q};
                    z80fi_insn_len   <= 3'd2;
                    z80fi_mem_rdata  <= m_q;
                    z80fi_reg_bc_out <= bc_next;
                    z80fi_reg_hl_out <= hl_next;
                    z80fi_reg_ip_out <= ip_next;
                    z80fi_reg_f_out  <= f_next;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_block_compare_unit.sv
// Directed bench for z80_block_compare_unit: hand-computed retire packets, wait states,
// ignored mid-read starts, ack timeout, illegal opcode and asynchronous reset.
module tb_z80_block_compare_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] insn = '0;
    logic [7:0]  reg_a_in = '0;
    logic [7:0]  reg_f_in = '0;
    logic [15:0] reg_bc_in = '0;
    logic [15:0] reg_hl_in = '0;
    logic [15:0] reg_ip_in = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rd_ack = 1'b0;

    logic        ready, mem_rd_req, insn_err, z80fi_valid;
    logic [15:0] mem_raddr;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [7:0]  z80fi_mem_rdata, z80fi_reg_f_out;
    logic [15:0] z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out;
    logic [1:0]  dbg_state;

    // Second instance with a short timeout; its ack is never driven high.
    logic        t_start = 1'b0;
    logic        t_ack = 1'b0;
    logic        t_ready, t_req, t_err, t_valid;
    logic [15:0] t_raddr;
    logic [31:0] t_insn_o;
    logic [2:0]  t_len;
    logic [7:0]  t_mrd, t_f;
    logic [15:0] t_bc, t_hl, t_ip;
    logic [1:0]  t_state;

    int checks = 0;
    int passed = 0;

    // Per-operation observations collected by run_op
    int          valid_cnt, lat, req_cycles, err_cnt;
    logic        raddr_ok, ready_ok;
    logic [15:0] raddr_seen;

    z80_block_compare_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .insn(insn),
        .reg_a_in(reg_a_in), .reg_f_in(reg_f_in), .reg_bc_in(reg_bc_in),
        .reg_hl_in(reg_hl_in), .reg_ip_in(reg_ip_in), .mem_rd_req(mem_rd_req),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rd_ack(mem_rd_ack),
        .insn_err(insn_err), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_mem_rdata(z80fi_mem_rdata),
        .z80fi_reg_bc_out(z80fi_reg_bc_out), .z80fi_reg_hl_out(z80fi_reg_hl_out),
        .z80fi_reg_ip_out(z80fi_reg_ip_out), .z80fi_reg_f_out(z80fi_reg_f_out),
        .dbg_state(dbg_state)
    );

    z80_block_compare_unit #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .start(t_start), .ready(t_ready), .insn(insn),
        .reg_a_in(reg_a_in), .reg_f_in(reg_f_in), .reg_bc_in(reg_bc_in),
        .reg_hl_in(reg_hl_in), .reg_ip_in(reg_ip_in), .mem_rd_req(t_req),
        .mem_raddr(t_raddr), .mem_rdata(mem_rdata), .mem_rd_ack(t_ack),
        .insn_err(t_err), .z80fi_valid(t_valid), .z80fi_insn(t_insn_o),
        .z80fi_insn_len(t_len), .z80fi_mem_rdata(t_mrd),
        .z80fi_reg_bc_out(t_bc), .z80fi_reg_hl_out(t_hl),
        .z80fi_reg_ip_out(t_ip), .z80fi_reg_f_out(t_f),
        .dbg_state(t_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver: launch one instruction and watch the unit for a fixed 12-cycle window.
    // lat = number of rising edges from the start-sampling edge (counted as 1) to valid.
    task automatic run_op(input logic [15:0] i_insn, input logic [7:0] a, input logic [7:0] f,
                          input logic [15:0] bc, input logic [15:0] hl, input logic [15:0] ip,
                          input logic [7:0] m, input int waits, input logic extra_starts);
        int nreq;
        @(negedge clk);
        insn = i_insn; reg_a_in = a; reg_f_in = f;
        reg_bc_in = bc; reg_hl_in = hl; reg_ip_in = ip;
        start = 1'b1;
        valid_cnt = 0; lat = 0; req_cycles = 0; err_cnt = 0; nreq = 0;
        raddr_ok = 1'b1; ready_ok = 1'b1; raddr_seen = 16'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_rd_ack = 1'b0;
            if (z80fi_valid) begin
                valid_cnt++;
                if (lat == 0) lat = c;
            end
            if (insn_err) err_cnt++;
            if (mem_rd_req) begin
                req_cycles++;
                if (ready !== 1'b0) ready_ok = 1'b0;
                if (nreq == 0) raddr_seen = mem_raddr;
                else if (mem_raddr !== raddr_seen) raddr_ok = 1'b0;
                if (extra_starts) start = 1'b1;
                if (nreq >= waits) begin
                    mem_rd_ack = 1'b1;
                    mem_rdata  = m;
                end else begin
                    mem_rdata = ~m;
                end
                nreq++;
            end
            // Corrupt the read-data bus whenever it should be ignored
            if (!mem_rd_ack) mem_rdata = 8'hC3;
        end
        // Scrub the inputs so only latched values can reach the packet
        insn = 16'h0000; reg_a_in = 8'h00; reg_f_in = 8'h00;
        reg_bc_in = 16'h0; reg_hl_in = 16'h0; reg_ip_in = 16'h0;
    endtask

    task automatic test_reset();
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ready); else passed++;
        checks++; if (mem_rd_req !== 1'b0) $display("FAIL reset_req: got %b exp 0", mem_rd_req); else passed++;
        checks++; if ({z80fi_valid, insn_err, z80fi_reg_f_out, z80fi_insn_len} !== 13'h0)
            $display("FAIL reset_outs: got %h exp 0", {z80fi_valid, insn_err, z80fi_reg_f_out, z80fi_insn_len});
        else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else passed++;
    endtask

    task automatic test_cpd_basic();
        run_op(16'hA9ED, 8'h42, 8'h29, 16'h0001, 16'h1000, 16'h0100, 8'h42, 0, 1'b0);
        checks++; if (raddr_seen !== 16'h1000) $display("FAIL cpd_raddr: got %h exp 1000", raddr_seen); else passed++;
        checks++; if (lat !== 3) $display("FAIL cpd_latency: got %0d exp 3", lat); else passed++;
        checks++; if (valid_cnt !== 1) $display("FAIL cpd_valid_cnt: got %0d exp 1", valid_cnt); else passed++;
        checks++; if (z80fi_reg_f_out !== 8'h7B) $display("FAIL cpd_f: got %h exp 7B", z80fi_reg_f_out); else passed++;
        checks++; if (z80fi_reg_bc_out !== 16'h0000) $display("FAIL cpd_bc: got %h exp 0000", z80fi_reg_bc_out); else passed++;
        checks++; if (z80fi_reg_hl_out !== 16'h0FFF) $display("FAIL cpd_hl: got %h exp 0FFF", z80fi_reg_hl_out); else passed++;
        checks++; if (z80fi_reg_ip_out !== 16'h0102) $display("FAIL cpd_ip: got %h exp 0102", z80fi_reg_ip_out); else passed++;
        checks++; if (z80fi_insn !== 32'h0000A9ED) $display("FAIL cpd_insn: got %h exp 0000A9ED", z80fi_insn); else passed++;
        checks++; if (z80fi_insn_len !== 3'd2) $display("FAIL cpd_len: got %0d exp 2", z80fi_insn_len); else passed++;
        checks++; if (z80fi_mem_rdata !== 8'h42) $display("FAIL cpd_mrd: got %h exp 42", z80fi_mem_rdata); else passed++;
    endtask

    task automatic test_cpir_repeat();
        run_op(16'hB1ED, 8'h10, 8'h00, 16'h0003, 16'h2000, 16'h0200, 8'h20, 0, 1'b0);
        checks++; if (z80fi_reg_f_out !== 8'h96) $display("FAIL cpir_rep_f: got %h exp 96", z80fi_reg_f_out); else passed++;
        checks++; if ({z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out} !== 48'h0002_2001_0200)
            $display("FAIL cpir_rep_regs: got %h exp 000220010200", {z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out});
        else passed++;
        // Match ends the repeat: IP advances
        run_op(16'hB1ED, 8'h20, 8'h00, 16'h0003, 16'h2000, 16'h0200, 8'h20, 0, 1'b0);
        checks++; if (z80fi_reg_f_out !== 8'h56) $display("FAIL cpir_match_f: got %h exp 56", z80fi_reg_f_out); else passed++;
        checks++; if (z80fi_reg_ip_out !== 16'h0202) $display("FAIL cpir_match_ip: got %h exp 0202", z80fi_reg_ip_out); else passed++;
        // CPDR with BC reaching zero and no match also ends the repeat
        run_op(16'hB9ED, 8'h01, 8'h00, 16'h0001, 16'h3000, 16'h0300, 8'h02, 0, 1'b0);
        checks++; if ({z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out} !== 56'h82_0000_2FFF_0302)
            $display("FAIL cpdr_bc0: got %h exp 8200002FFF0302",
                     {z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out});
        else passed++;
    endtask

    task automatic test_cpi_wrap();
        run_op(16'hA1ED, 8'h55, 8'hFF, 16'h0000, 16'hFFFF, 16'h0400, 8'h33, 0, 1'b0);
        checks++; if (z80fi_reg_f_out !== 8'h3F) $display("FAIL cpi_wrap_f: got %h exp 3F", z80fi_reg_f_out); else passed++;
        checks++; if ({z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out} !== 48'hFFFF_0000_0402)
            $display("FAIL cpi_wrap_regs: got %h exp FFFF00000402", {z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out});
        else passed++;
    endtask

    task automatic test_wait_and_extra_start();
        run_op(16'hA1ED, 8'h80, 8'h00, 16'h0010, 16'h5A5A, 16'h0500, 8'h01, 3, 1'b1);
        checks++; if (req_cycles !== 4) $display("FAIL wait_req_cycles: got %0d exp 4", req_cycles); else passed++;
        checks++; if (raddr_ok !== 1'b1 || raddr_seen !== 16'h5A5A)
            $display("FAIL wait_raddr: got %h stable=%b exp 5A5A", raddr_seen, raddr_ok);
        else passed++;
        checks++; if (ready_ok !== 1'b1) $display("FAIL wait_ready: got %b exp 1", ready_ok); else passed++;
        checks++; if (valid_cnt !== 1) $display("FAIL wait_valid_cnt: got %0d exp 1", valid_cnt); else passed++;
        checks++; if (lat !== 6) $display("FAIL wait_latency: got %0d exp 6", lat); else passed++;
        // 80-01 = 7F, half 0+E+1 no carry
        checks++; if ({z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out} !== 40'h06_000F_5A5B)
            $display("FAIL wait_result: got %h exp 06000F5A5B", {z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out});
        else passed++;
    endtask

    task automatic test_illegal();
        run_op(16'h00ED, 8'h00, 8'h00, 16'h0001, 16'h1234, 16'h0000, 8'h00, 0, 1'b0);
        checks++; if (err_cnt !== 1) $display("FAIL illegal_err: got %0d exp 1", err_cnt); else passed++;
        checks++; if (req_cycles !== 0) $display("FAIL illegal_req: got %0d exp 0", req_cycles); else passed++;
        checks++; if (valid_cnt !== 0) $display("FAIL illegal_valid: got %0d exp 0", valid_cnt); else passed++;
    endtask

    task automatic test_timeout();
        int nreq, nerr, nval;
        nreq = 0; nerr = 0; nval = 0;
        @(negedge clk);
        insn = 16'hA1ED; reg_hl_in = 16'h0777; t_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            t_start = 1'b0;
            if (t_req) nreq++;
            if (t_err) nerr++;
            if (t_valid) nval++;
        end
        checks++; if (nreq !== 4) $display("FAIL timeout_req: got %0d exp 4", nreq); else passed++;
        checks++; if (nerr !== 1) $display("FAIL timeout_err: got %0d exp 1", nerr); else passed++;
        checks++; if (nval !== 0) $display("FAIL timeout_valid: got %0d exp 0", nval); else passed++;
        checks++; if (t_ready !== 1'b1) $display("FAIL timeout_ready: got %b exp 1", t_ready); else passed++;
    endtask

    task automatic test_async_reset();
        int n;
        logic saw_req;
        saw_req = 1'b0;
        @(negedge clk);
        insn = 16'hA9ED; reg_hl_in = 16'h4444; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_req = mem_rd_req;
        checks++; if (saw_req !== 1'b1) $display("FAIL areset_pre_req: got %b exp 1", saw_req); else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_rd_req !== 1'b0) $display("FAIL areset_req: got %b exp 0", mem_rd_req); else passed++;
        checks++; if ({z80fi_valid, insn_err, z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out,
                       z80fi_reg_f_out, z80fi_insn, mem_raddr} !== 114'h0)
            $display("FAIL areset_outs: got nonzero packet bc=%h hl=%h f=%h", z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_f_out);
        else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL areset_ready: got %b exp 1", ready); else passed++;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (z80fi_valid || insn_err) n++;
        end
        reset_n = 1'b1;
        checks++; if (n !== 0) $display("FAIL areset_no_pulse: got %0d exp 0", n); else passed++;
        run_op(16'hA9ED, 8'h42, 8'h29, 16'h0001, 16'h1000, 16'h0100, 8'h42, 0, 1'b0);
        checks++; if ({z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out} !== 56'h7B_0000_0FFF_0102)
            $display("FAIL areset_fresh_cpd: got %h exp 7B00000FFF0102",
                     {z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_hl_out, z80fi_reg_ip_out});
        else passed++;
        checks++; if (lat !== 3) $display("FAIL areset_fresh_lat: got %0d exp 3", lat); else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_cpd_basic();
        test_cpir_repeat();
        test_cpi_wrap();
        test_wait_and_extra_start();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
